// File: rtl/sevenseg_pkg.sv
// Shared glyph constants, FSM state type and digit-index helpers for the
// multiplexed 7-segment scan decoder.
package sevenseg_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {IDLE, COLLECT} state_t;

  typedef logic [1:0] digit_idx_t;

  function automatic logic [2:0] low_count(input logic [3:0] an);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, ~an[i]};
    end
    return n;
  endfunction

  // Index of the lowest low bit; only meaningful when exactly one bit is low.
  function automatic digit_idx_t low_index(input logic [3:0] an);
    digit_idx_t idx;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!an[i]) idx = digit_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sevenseg_decoder.sv
// Combinational glyph-to-BCD decode; the exact inverse of the display encoder.
// Any pattern that is not one of the ten digit glyphs yields 4'hF with err set.
module sevenseg_decoder
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       err
);

  always_comb begin
    digit = 4'hF;
    err   = 1'b0;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Rebuilds the four scanned digits of a multiplexed 7-segment display and publishes
// complete frames; a capture lands 2+c_settle_cycles cycles after the last input edge.
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int unsigned c_clk_freq       = 100_000_000,
  parameter int unsigned c_settle_cycles  = 16,
  parameter int unsigned c_timeout_cycles = 400_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  an_i,
  input  logic [6:0]  seg_i,
  input  logic        dp_i,
  output logic [15:0] digits_o,
  output logic [3:0]  dp_o,
  output logic        frame_valid_o,
  output logic        seg_err_o,
  output logic        an_err_o,
  output logic        timeout_o
);

  localparam int unsigned SW = $clog2(c_settle_cycles);
  localparam int unsigned TW = $clog2(c_timeout_cycles + 1);
  localparam logic [SW-1:0] SETTLE_ARM   = SW'(c_settle_cycles - 2);
  localparam logic [SW-1:0] SETTLE_MAX   = SW'(c_settle_cycles - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(c_timeout_cycles - 1);

  if (c_clk_freq == 0 || c_settle_cycles < 2 || c_timeout_cycles < 2) begin : g_bad_params
    $error("sevenseg_scan_decoder: parameter out of range");
  end

  logic [11:0]   sync_q1, sync_q2, prev;
  logic          changed;
  logic [SW-1:0] settle_cnt;
  logic          cap;
  logic [11:0]   cap_dat;

  assign changed = (sync_q2 != prev);

  // Stages reset to all-ones so the display looks blank until real data arrives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q1    <= '1;
      sync_q2    <= '1;
      prev       <= '1;
      settle_cnt <= '0;
      cap        <= 1'b0;
      cap_dat    <= '1;
    end else begin
      sync_q1 <= {an_i, seg_i, dp_i};
      sync_q2 <= sync_q1;
      prev    <= sync_q2;
      cap     <= !changed && (settle_cnt == SETTLE_ARM);
      cap_dat <= sync_q2;
      if (changed) begin
        settle_cnt <= '0;
      end else if (settle_cnt != SETTLE_MAX) begin
        settle_cnt <= settle_cnt + SW'(1);
      end
    end
  end

  logic [3:0]  cap_an;
  logic [6:0]  cap_seg;
  logic        cap_dp;
  logic [2:0]  cap_lows;
  logic        cap_multi, cap_one;
  digit_idx_t  cap_idx;
  logic [3:0]  dec_digit;
  logic        dec_err;

  assign {cap_an, cap_seg, cap_dp} = cap_dat;
  assign cap_lows  = low_count(cap_an);
  assign cap_multi = (cap_lows > 3'd1);
  assign cap_one   = (cap_lows == 3'd1);
  assign cap_idx   = low_index(cap_an);

  sevenseg_decoder u_decoder (
    .seg   (cap_seg),
    .digit (dec_digit),
    .err   (dec_err)
  );

  state_t          state;
  logic [3:0]      seen, seen_next;
  logic [3:0][3:0] shadow;
  logic [3:0]      shadow_dp;
  logic            publish;
  logic [TW-1:0]   timeout_cnt;

  assign seen_next = seen | (4'b0001 << cap_idx);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      seen          <= '0;
      shadow        <= '0;
      shadow_dp     <= '0;
      publish       <= 1'b0;
      timeout_cnt   <= '0;
      digits_o      <= '0;
      dp_o          <= '0;
      frame_valid_o <= 1'b0;
      seg_err_o     <= 1'b0;
      an_err_o      <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      frame_valid_o <= 1'b0;
      seg_err_o     <= 1'b0;
      an_err_o      <= 1'b0;
      timeout_o     <= 1'b0;
      publish       <= 1'b0;

      if (publish) begin
        digits_o      <= shadow;
        dp_o          <= shadow_dp;
        frame_valid_o <= 1'b1;
        seen          <= '0;
      end

      // A capture in the same cycle as an expiring timeout takes precedence.
      if (cap) begin
        timeout_cnt <= '0;
        if (cap_multi) begin
          an_err_o <= 1'b1;
        end else if (cap_one) begin
          shadow[cap_idx]    <= dec_digit;
          shadow_dp[cap_idx] <= ~cap_dp;
          seg_err_o          <= dec_err;
          seen               <= seen_next;
          state              <= COLLECT;
          publish            <= (seen_next == 4'b1111);
        end
      end else if (state == COLLECT) begin
        if (timeout_cnt == TIMEOUT_LAST) begin
          timeout_o   <= 1'b1;
          seen        <= '0;
          state       <= IDLE;
          timeout_cnt <= '0;
        end else begin
          timeout_cnt <= timeout_cnt + TW'(1);
        end
      end
    end
  end

endmodule
